menu_processor: RTL

MENU_PROCESSOR -- requirements
Module: menu_processor

---
 rtl/menu_pkg.sv | 38 +++
 rtl/menu_processor_blink.sv | 34 +++
 rtl/menu_processor.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/menu_pkg.sv
// Shared definitions for the menu processor: state encoding, key codes,
// interrupt codes and the attribute field of a display word.
package menu_pkg;

    localparam logic [4:0] S_INIT     = 5'd0;
    localparam logic [4:0] S_ARM      = 5'd1;
    localparam logic [4:0] S_IDLE     = 5'd2;
    localparam logic [4:0] S_TICK_ACK = 5'd3;
    localparam logic [4:0] S_BLINK    = 5'd4;
    localparam logic [4:0] S_GPU_CHK  = 5'd5;
    localparam logic [4:0] S_RD       = 5'd6;
    localparam logic [4:0] S_LD       = 5'd7;
    localparam logic [4:0] S_MASK     = 5'd8;
    localparam logic [4:0] S_WR       = 5'd9;
    localparam logic [4:0] S_NEXT     = 5'd10;
    localparam logic [4:0] S_DRAW     = 5'd11;
    localparam logic [4:0] S_END      = 5'd12;
    localparam logic [4:0] S_KEY_ACK  = 5'd13;
    localparam logic [4:0] S_KEY_EXEC = 5'd14;
    localparam logic [4:0] S_DONE     = 5'd15;
    localparam logic [4:0] S_ERR      = 5'd16;

    localparam logic [7:0] KEY_UP_DEF     = 8'h75;
    localparam logic [7:0] KEY_DOWN_DEF   = 8'h72;
    localparam logic [7:0] KEY_SELECT_DEF = 8'h20;

    localparam logic [1:0] IRQ_TICK = 2'd0;
    localparam logic [1:0] IRQ_KEY  = 2'd1;

    localparam int ATTR_HI = 10;
    localparam int ATTR_LO = 8;

    // Menu item a display word belongs to (0 = plain text, n = item n-1).
    function automatic logic [2:0] attr_of(input logic [15:0] word);
        return word[ATTR_HI:ATTR_LO];
    endfunction

endpackage

// File: rtl/menu_processor_blink.sv
// Blink timer: counts frame ticks and toggles the highlight visibility.
module blink_timer
    import menu_pkg::*;
#(
    parameter int PERIOD = 24
) (
    input  logic CLK,
    input  logic RESET,
    input  logic tick,
    input  logic force_on,
    input  logic clear,
    output logic visible
);

    localparam logic [7:0] LAST = 8'(PERIOD - 1);

    logic [7:0] count;

    // Visibility flips on the tick where the counter sits at zero.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count   <= 8'd0;
            visible <= 1'b0;
        end else if (force_on) begin
            count   <= 8'd1;
            visible <= 1'b1;
        end else if (tick) begin
            if (count == 8'd0)
                visible <= ~visible;
            count <= (count == LAST) ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/menu_processor.sv
// Menu processor: on each frame tick copies the source frame into the
// display region, blanking the highlighted item's words while the blink
// is off; key interrupts move the highlight or commit the selection.
module menu_processor
    import menu_pkg::*;
#(
    parameter logic [15:0] FRAME_BASE   = 16'h0800,
    parameter logic [15:0] FRAME_LEN    = 16'h0500,
    parameter logic [15:0] REGION_XOR   = 16'hA800,
    parameter int          BLINK_PERIOD = 24,
    parameter int          NUM_ITEMS    = 4,
    parameter logic [7:0]  KEY_UP       = KEY_UP_DEF,
    parameter logic [7:0]  KEY_DOWN     = KEY_DOWN_DEF,
    parameter logic [7:0]  KEY_SELECT   = KEY_SELECT_DEF,
    localparam int         SEL_W        = $clog2(NUM_ITEMS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    output logic             MEM_ENABLE,
    output logic             MEM_WRITE,
    output logic [15:0]      MEM_ADDR,
    input  logic [15:0]      MEM_DATA_R,
    output logic [15:0]      MEM_DATA_W,
    input  logic             GPU_READY,
    output logic             GPU_DRAW,
    input  logic [7:0]       KBD_KEY,
    input  logic [1:0]       INT_IRQ,
    output logic             INT_IACK,
    output logic             INT_IEND,
    output logic             SWITCH_REQUEST,
    output logic [SEL_W-1:0] SELECTION,
    output logic             FATAL_ERROR
);

    localparam logic [16:0]      FRAME_END = {1'b0, FRAME_BASE} + {1'b0, FRAME_LEN};
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_ITEMS - 1);

    if (FRAME_END > 17'h10000 || FRAME_LEN == 16'd0) begin : g_bad_frame
        $error("menu_processor: frame must be non-empty and end at or below 16'hFFFF+1");
    end

    logic [4:0]       state;
    logic [15:0]      buffer;
    logic [SEL_W-1:0] sel;
    logic [7:0]       key_q;
    logic             ld_wait;
    logic             visible;
    logic             wr_in_frame;
    logic             highlight;
    logic             key_move;
    logic [16:0]      next_addr;

    assign wr_in_frame = ({1'b0, MEM_ADDR} >= {1'b0, FRAME_BASE}) && ({1'b0, MEM_ADDR} < FRAME_END);
    assign highlight   = (attr_of(buffer) == 3'(sel) + 3'd1);
    assign key_move    = (key_q == KEY_UP) || (key_q == KEY_DOWN);
    assign next_addr   = {1'b0, MEM_ADDR ^ REGION_XOR} + 17'd1;

    blink_timer #(.PERIOD(BLINK_PERIOD)) u_blink (
        .CLK      (CLK),
        .RESET    (RESET),
        .tick     (state == S_BLINK),
        .force_on (state == S_KEY_EXEC && key_move),
        .clear    (state == S_INIT),
        .visible  (visible)
    );

    // Strobes decode straight from the state; a write that would land on
    // the source frame is never driven onto the bus.
    assign MEM_ENABLE     = (state == S_RD) || (state == S_WR && !wr_in_frame);
    assign MEM_WRITE      = (state == S_WR) && !wr_in_frame;
    assign MEM_DATA_W     = buffer;
    assign GPU_DRAW       = (state == S_DRAW);
    assign INT_IACK       = (state == S_TICK_ACK) || (state == S_KEY_ACK);
    assign INT_IEND       = (state == S_END) || (state == S_KEY_EXEC);
    assign SWITCH_REQUEST = (state == S_DONE);
    assign FATAL_ERROR    = (state == S_ERR);

    // Main sequencer. LD spans two cycles (capture, then settle) so every
    // copied word costs a fixed six cycles. A fatal error survives ENABLE
    // toggles; only RESET clears it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_INIT;
            MEM_ADDR  <= 16'd0;
            buffer    <= 16'd0;
            sel       <= '0;
            key_q     <= 8'd0;
            ld_wait   <= 1'b0;
            SELECTION <= '0;
        end else if (!ENABLE && state != S_ERR) begin
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT: begin
                    buffer  <= 16'd0;
                    sel     <= '0;
                    ld_wait <= 1'b0;
                    state   <= S_ARM;
                end
                S_ARM: begin
                    MEM_ADDR <= FRAME_BASE;
                    state    <= S_IDLE;
                end
                S_IDLE: begin
                    case (INT_IRQ)
                        IRQ_TICK: state <= S_TICK_ACK;
                        IRQ_KEY:  state <= S_KEY_ACK;
                        default:  state <= S_IDLE;
                    endcase
                end
                S_TICK_ACK: state <= S_BLINK;
                S_BLINK:    state <= S_GPU_CHK;
                S_GPU_CHK:  state <= GPU_READY ? S_RD : S_END;
                S_RD: begin
                    ld_wait <= 1'b0;
                    state   <= S_LD;
                end
                S_LD: begin
                    if (!ld_wait) begin
                        buffer  <= MEM_DATA_R;
                        ld_wait <= 1'b1;
                    end else begin
                        state <= S_MASK;
                    end
                end
                S_MASK: begin
                    MEM_ADDR <= MEM_ADDR ^ REGION_XOR;
                    if (highlight && !visible)
                        buffer <= 16'd0;
                    state <= S_WR;
                end
                S_WR: state <= wr_in_frame ? S_ERR : S_NEXT;
                S_NEXT: begin
                    MEM_ADDR <= next_addr[15:0];
                    state    <= (next_addr < FRAME_END) ? S_RD : S_DRAW;
                end
                S_DRAW: state <= S_END;
                S_END:  state <= S_ARM;
                S_KEY_ACK: begin
                    key_q <= KBD_KEY;
                    state <= S_KEY_EXEC;
                end
                S_KEY_EXEC: begin
                    state <= S_ARM;
                    if (key_q == KEY_UP)
                        sel <= (sel == '0) ? SEL_MAX : sel - 1'b1;
                    else if (key_q == KEY_DOWN)
                        sel <= (sel == SEL_MAX) ? '0 : sel + 1'b1;
                    else if (key_q == KEY_SELECT)
                        state <= S_DONE;
                end
                S_DONE: SELECTION <= sel;
                S_ERR:  state <= S_ERR;
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
